// File: rtl/agc_servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : agc_servo_pkg
//  Description : Shared types and constants for the AGC servo controller.
//                Holds the FSM state enum, datapath widths, the two's-
//                complement offset limits and the scale step helper.
//                Optional feature macro: AGC_SERVO_OFFSET_EN (enables the
//                DC-offset loop; default build leaves it disabled).
//  Revision    : 1.0 - initial release
// ============================================================================
package agc_servo_pkg;

   localparam int SCALE_W  = 17;
   localparam int OFFSET_W = 8;
   localparam int SQ_W     = 24;
   localparam int CNT_W    = 21;
   localparam int DIFF_W   = CNT_W + 1;   // signed gt - lt
   localparam int ITER_W   = 8;

   // Offset limits as raw two's-complement bit patterns.
   localparam logic [OFFSET_W-1:0] OFFSET_MAX = 8'h7F;   // +127
   localparam logic [OFFSET_W-1:0] OFFSET_MIN = 8'h80;   // -128

   localparam logic [SCALE_W-1:0]  SCALE_SAT  = 17'h1FFFF;

`ifdef AGC_SERVO_OFFSET_EN
   localparam bit OFFSET_EN = 1'b1;
`else
   localparam bit OFFSET_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_APPLY = 3'd2,
      S_CLEAR = 3'd3,
      S_TICK  = 3'd4,
      S_WAIT  = 3'd5,
      S_EVAL  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   // Proportional scale step; never zero so a small scale can still move.
   function automatic logic [SCALE_W-1:0] scale_step(
      input logic [SCALE_W-1:0] scale,
      input int unsigned        shift
   );
      logic [SCALE_W-1:0] step;
      step = scale >> shift;
      if (step == '0) begin
         step = {{(SCALE_W-1){1'b0}}, 1'b1};
      end
      return step;
   endfunction

endpackage : agc_servo_pkg
`default_nettype wire

// File: rtl/agc_servo_step.sv
`default_nettype none
// ============================================================================
//  Module      : agc_servo_step
//  Description : One-cycle registered servo step. Captures the accumulator
//                readings when i_load is high and produces the next scale,
//                next offset and the in-band (lock) flag for the following
//                cycle.
//  Ports       : clk, rst          - clock / synchronous active-high reset
//                i_load            - capture strobe (WAIT with done)
//                i_scale/i_offset  - current scale and offset
//                i_sq/i_gt/i_lt    - accumulator readings
//                o_next_scale      - stepped scale
//                o_next_offset     - stepped offset (0 when loop disabled)
//                o_in_band         - readings inside lock window
//  Macro       : AGC_SERVO_OFFSET_EN (offset loop and gt/lt lock term)
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_servo_step
   import agc_servo_pkg::*;
#(
   parameter logic [SQ_W-1:0]  SQ_TARGET   = 24'h200000,
   parameter logic [SQ_W-1:0]  SQ_DEADBAND = 24'h020000,
   parameter logic [CNT_W-1:0] GL_DEADBAND = 21'd256,
   parameter int unsigned      SCALE_SHIFT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [SCALE_W-1:0]  i_scale,
   input  logic [OFFSET_W-1:0] i_offset,
   input  logic [SQ_W-1:0]     i_sq,
   input  logic [CNT_W-1:0]    i_gt,
   input  logic [CNT_W-1:0]    i_lt,
   output logic [SCALE_W-1:0]  o_next_scale,
   output logic [OFFSET_W-1:0] o_next_offset,
   output logic                o_in_band
);

   // Window edges. Upper edge is one bit wider so target+deadband cannot
   // wrap; lower edge floors at zero.
   localparam logic [SQ_W:0]   C_SQ_HI = {1'b0, SQ_TARGET} + {1'b0, SQ_DEADBAND};
   localparam logic [SQ_W-1:0] C_SQ_LO = (SQ_TARGET > SQ_DEADBAND) ?
                                         (SQ_TARGET - SQ_DEADBAND) : '0;
   localparam logic signed [DIFF_W-1:0] C_GL_POS = $signed({1'b0, GL_DEADBAND});
   localparam logic signed [DIFF_W-1:0] C_GL_NEG = -C_GL_POS;

   logic [SCALE_W-1:0]        w_step;
   logic [SCALE_W:0]          w_scale_sum;
   logic                      w_sq_above;
   logic                      w_sq_below;
   logic signed [DIFF_W-1:0]  w_diff;
   logic                      w_gl_pos;
   logic                      w_gl_neg;
   logic [SCALE_W-1:0]        w_next_scale;
   logic [OFFSET_W-1:0]       w_next_offset;
   logic                      w_in_band;

   logic [SCALE_W-1:0]        r_next_scale;
   logic [OFFSET_W-1:0]       r_next_offset;
   logic                      r_in_band;

   assign w_step      = scale_step(i_scale, SCALE_SHIFT);
   assign w_scale_sum = {1'b0, i_scale} + {1'b0, w_step};

   assign w_sq_above  = {1'b0, i_sq} > C_SQ_HI;
   assign w_sq_below  = i_sq < C_SQ_LO;

   assign w_diff      = $signed({1'b0, i_gt}) - $signed({1'b0, i_lt});
   assign w_gl_pos    = OFFSET_EN && (w_diff > C_GL_POS);
   assign w_gl_neg    = OFFSET_EN && (w_diff < C_GL_NEG);

   always_comb begin
      w_next_scale = i_scale;
      if (w_sq_above) begin
         // Decrease, never below 1.
         w_next_scale = (i_scale > w_step) ? (i_scale - w_step) :
                                             {{(SCALE_W-1){1'b0}}, 1'b1};
      end else if (w_sq_below) begin
         // Increase, saturating at full scale.
         w_next_scale = w_scale_sum[SCALE_W] ? SCALE_SAT : w_scale_sum[SCALE_W-1:0];
      end
   end

   always_comb begin
      w_next_offset = OFFSET_EN ? i_offset : '0;
      if (w_gl_pos) begin
         // More samples above threshold than below: pull the DC level down.
         w_next_offset = (i_offset == OFFSET_MIN) ? OFFSET_MIN : (i_offset - 8'd1);
      end else if (w_gl_neg) begin
         w_next_offset = (i_offset == OFFSET_MAX) ? OFFSET_MAX : (i_offset + 8'd1);
      end
   end

   assign w_in_band = !w_sq_above && !w_sq_below && !w_gl_pos && !w_gl_neg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_next_scale  <= '0;
         r_next_offset <= '0;
         r_in_band     <= 1'b0;
      end else if (i_load) begin
         r_next_scale  <= w_next_scale;
         r_next_offset <= w_next_offset;
         r_in_band     <= w_in_band;
      end
   end

   assign o_next_scale  = r_next_scale;
   assign o_next_offset = r_next_offset;
   assign o_in_band     = r_in_band;

endmodule : agc_servo_step
`default_nettype wire

// File: rtl/agc_servo.sv
`default_nettype none
// ============================================================================
//  Module      : agc_servo
//  Description : Closed-loop AGC controller. Loads scale/offset into the
//                AGC core, applies them, clears and starts an accumulation
//                period, waits for completion, then steps scale (and
//                optionally offset) toward the target until the readings
//                fall inside the lock window or the iteration limit is hit.
//  Ports       : clk_i, rst_i            - aclk / sync active-high reset
//                start_i, abort_i        - run control pulses
//                sq/gt/lt_accum_i        - AGC core statistics
//                agc_done_i              - statistics valid pulse
//                agc_tick_o, agc_rst_o   - accumulation start / clear pulses
//                agc_scale_o/_ce_o       - scale value and load pulse
//                agc_offset_o/_ce_o      - offset value and load pulse
//                agc_apply_o             - apply loaded values pulse
//                busy_o, locked_o,
//                timeout_o, iter_o       - status
//  Macro       : AGC_SERVO_OFFSET_EN - enables the offset loop; when
//                undefined the offset stays 0, its load pulse never fires
//                and lock depends on the square accumulator only.
//  Revision    : 1.0 - initial release
// ============================================================================
module agc_servo
   import agc_servo_pkg::*;
#(
   parameter logic [SCALE_W-1:0] INIT_SCALE  = 17'h04000,
   parameter logic [SQ_W-1:0]    SQ_TARGET   = 24'h200000,
   parameter logic [SQ_W-1:0]    SQ_DEADBAND = 24'h020000,
   parameter logic [CNT_W-1:0]   GL_DEADBAND = 21'd256,
   parameter int unsigned        SCALE_SHIFT = 4,
   parameter logic [ITER_W-1:0]  MAX_ITER    = 8'd32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                abort_i,
   input  logic [SQ_W-1:0]     sq_accum_i,
   input  logic [CNT_W-1:0]    gt_accum_i,
   input  logic [CNT_W-1:0]    lt_accum_i,
   input  logic                agc_done_i,
   output logic                agc_tick_o,
   output logic                agc_rst_o,
   output logic [SCALE_W-1:0]  agc_scale_o,
   output logic [OFFSET_W-1:0] agc_offset_o,
   output logic                agc_scale_ce_o,
   output logic                agc_offset_ce_o,
   output logic                agc_apply_o,
   output logic                busy_o,
   output logic                locked_o,
   output logic                timeout_o,
   output logic [ITER_W-1:0]   iter_o
);

   state_t               r_state;
   logic [SCALE_W-1:0]   r_scale;
   logic [OFFSET_W-1:0]  r_offset;
   logic                 r_scale_ce;
   logic                 r_offset_ce;
   logic                 r_apply;
   logic                 r_agc_rst;
   logic                 r_tick;
   logic                 r_busy;
   logic                 r_locked;
   logic                 r_timeout;
   logic [ITER_W-1:0]    r_iter;

   logic                 w_load_step;
   logic [SCALE_W-1:0]   w_next_scale;
   logic [OFFSET_W-1:0]  w_next_offset;
   logic                 w_in_band;
   logic [ITER_W-1:0]    w_iter_inc;

   // Readings are captured on the same edge that leaves WAIT, so the step
   // results are ready when EVAL decides.
   assign w_load_step = (r_state == S_WAIT) && agc_done_i;
   assign w_iter_inc  = r_iter + 8'd1;

   agc_servo_step #(
      .SQ_TARGET   (SQ_TARGET),
      .SQ_DEADBAND (SQ_DEADBAND),
      .GL_DEADBAND (GL_DEADBAND),
      .SCALE_SHIFT (SCALE_SHIFT)
   ) u_step (
      .clk           (clk_i),
      .rst           (rst_i),
      .i_load        (w_load_step),
      .i_scale       (r_scale),
      .i_offset      (r_offset),
      .i_sq          (sq_accum_i),
      .i_gt          (gt_accum_i),
      .i_lt          (lt_accum_i),
      .o_next_scale  (w_next_scale),
      .o_next_offset (w_next_offset),
      .o_in_band     (w_in_band)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_scale     <= INIT_SCALE;
         r_offset    <= '0;
         r_scale_ce  <= 1'b0;
         r_offset_ce <= 1'b0;
         r_apply     <= 1'b0;
         r_agc_rst   <= 1'b0;
         r_tick      <= 1'b0;
         r_busy      <= 1'b0;
         r_locked    <= 1'b0;
         r_timeout   <= 1'b0;
         r_iter      <= '0;
      end else begin
         // Every pulse output is one cycle wide; it is raised on the edge
         // that enters its state.
         r_scale_ce  <= 1'b0;
         r_offset_ce <= 1'b0;
         r_apply     <= 1'b0;
         r_agc_rst   <= 1'b0;
         r_tick      <= 1'b0;

         if (abort_i) begin
            // Scale/offset and status hold; only the sequencing stops.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start_i) begin
                     r_state     <= S_LOAD;
                     r_busy      <= 1'b1;
                     r_locked    <= 1'b0;
                     r_timeout   <= 1'b0;
                     r_iter      <= '0;
                     r_scale     <= INIT_SCALE;
                     r_offset    <= '0;
                     r_scale_ce  <= 1'b1;
                     r_offset_ce <= OFFSET_EN;
                  end
               end
               S_LOAD: begin
                  r_state <= S_APPLY;
                  r_apply <= 1'b1;
               end
               S_APPLY: begin
                  r_state   <= S_CLEAR;
                  r_agc_rst <= 1'b1;
               end
               S_CLEAR: begin
                  r_state <= S_TICK;
                  r_tick  <= 1'b1;
               end
               S_TICK: begin
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (agc_done_i) begin
                     r_state <= S_EVAL;
                  end
               end
               S_EVAL: begin
                  r_iter <= w_iter_inc;
                  if (w_in_band) begin
                     r_state  <= S_DONE;
                     r_locked <= 1'b1;
                  end else if (w_iter_inc == MAX_ITER) begin
                     r_state   <= S_DONE;
                     r_timeout <= 1'b1;
                  end else begin
                     // New values appear together with their load pulses.
                     r_state     <= S_LOAD;
                     r_scale     <= w_next_scale;
                     r_offset    <= w_next_offset;
                     r_scale_ce  <= 1'b1;
                     r_offset_ce <= OFFSET_EN;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign agc_tick_o      = r_tick;
   assign agc_rst_o       = r_agc_rst;
   assign agc_scale_o     = r_scale;
   assign agc_offset_o    = r_offset;
   assign agc_scale_ce_o  = r_scale_ce;
   assign agc_offset_ce_o = r_offset_ce;
   assign agc_apply_o     = r_apply;
   assign busy_o          = r_busy;
   assign locked_o        = r_locked;
   assign timeout_o       = r_timeout;
   assign iter_o          = r_iter;

endmodule : agc_servo
`default_nettype wire

// File: tb/tb_agc_servo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agc_servo
//  Description : Self-checking directed bench for agc_servo. A main instance
//                covers reset, lock, timeout, offset, abort and mid-run
//                reset; two extra instances with extreme initial scales
//                cover the scale floor and saturation.
//  Macro       : AGC_SERVO_OFFSET_EN (selects offset-loop expectations)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agc_servo;

`ifdef AGC_SERVO_OFFSET_EN
   localparam logic EXP_OCE = 1'b1;
`else
   localparam logic EXP_OCE = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance stimulus / observation
   logic        rst = 1'b1, start_m = 1'b0, abort_m = 1'b0, done_m = 1'b0;
   logic [23:0] sq_m = '0;
   logic [20:0] gt = '0, lt = '0;
   logic        tick_m, arst_m, sce_m, oce_m, app_m, busy_m, lock_m, to_m;
   logic [16:0] scale_m;
   logic [7:0]  off_m, iter_m;

   // Edge instances
   logic        start_e = 1'b0, abort_e = 1'b0, done_e = 1'b0;
   logic        tick_lo, arst_lo, sce_lo, oce_lo, app_lo, busy_lo, lock_lo, to_lo;
   logic [16:0] scale_lo;
   logic [7:0]  off_lo, iter_lo;
   logic        tick_hi, arst_hi, sce_hi, oce_hi, app_hi, busy_hi, lock_hi, to_hi;
   logic [16:0] scale_hi;
   logic [7:0]  off_hi, iter_hi;

   agc_servo u_main (
      .clk_i(clk), .rst_i(rst), .start_i(start_m), .abort_i(abort_m),
      .sq_accum_i(sq_m), .gt_accum_i(gt), .lt_accum_i(lt), .agc_done_i(done_m),
      .agc_tick_o(tick_m), .agc_rst_o(arst_m), .agc_scale_o(scale_m),
      .agc_offset_o(off_m), .agc_scale_ce_o(sce_m), .agc_offset_ce_o(oce_m),
      .agc_apply_o(app_m), .busy_o(busy_m), .locked_o(lock_m),
      .timeout_o(to_m), .iter_o(iter_m)
   );

   agc_servo #(.INIT_SCALE(17'd1)) u_lo (
      .clk_i(clk), .rst_i(rst), .start_i(start_e), .abort_i(abort_e),
      .sq_accum_i(24'h800000), .gt_accum_i(gt), .lt_accum_i(lt), .agc_done_i(done_e),
      .agc_tick_o(tick_lo), .agc_rst_o(arst_lo), .agc_scale_o(scale_lo),
      .agc_offset_o(off_lo), .agc_scale_ce_o(sce_lo), .agc_offset_ce_o(oce_lo),
      .agc_apply_o(app_lo), .busy_o(busy_lo), .locked_o(lock_lo),
      .timeout_o(to_lo), .iter_o(iter_lo)
   );

   agc_servo #(.INIT_SCALE(17'h1FFF0)) u_hi (
      .clk_i(clk), .rst_i(rst), .start_i(start_e), .abort_i(abort_e),
      .sq_accum_i(24'h000000), .gt_accum_i(gt), .lt_accum_i(lt), .agc_done_i(done_e),
      .agc_tick_o(tick_hi), .agc_rst_o(arst_hi), .agc_scale_o(scale_hi),
      .agc_offset_o(off_hi), .agc_scale_ce_o(sce_hi), .agc_offset_ce_o(oce_hi),
      .agc_apply_o(app_hi), .busy_o(busy_hi), .locked_o(lock_hi),
      .timeout_o(to_hi), .iter_o(iter_hi)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Advance until the main instance shows its tick pulse (bounded).
   task automatic wait_tick_m(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (tick_m) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic wait_tick_e(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (tick_lo) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   // From a TICK cycle: sit in WAIT two cycles, then pulse done once.
   task automatic pulse_done_m();
      cyc();
      cyc();
      done_m = 1'b1;
      cyc();
      done_m = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc(); cyc();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         checks++;
         if ({tick_m, arst_m, sce_m, oce_m, app_m} !== 5'b0) begin
            errors++; $display("FAIL reset_pulses: got %b required 00000", {tick_m, arst_m, sce_m, oce_m, app_m});
         end
         checks++;
         if ({busy_m, lock_m, to_m} !== 3'b0 || iter_m !== 8'd0) begin
            errors++; $display("FAIL reset_status: busy/lock/to %b iter %0d required 000/0", {busy_m, lock_m, to_m}, iter_m);
         end
         checks++;
         if (scale_m !== 17'h04000 || off_m !== 8'h00) begin
            errors++; $display("FAIL reset_values: scale %h off %h required 04000/00", scale_m, off_m);
         end
      end
   endtask

   task automatic test_lock();
      bit ok;
      sq_m = 24'h200000; gt = 21'd1000; lt = 21'd1000;
      start_m = 1'b1;
      cyc();                 // edge N
      start_m = 1'b0;
      checks++;
      if ({sce_m, oce_m, app_m, arst_m, tick_m, busy_m} !== {1'b1, EXP_OCE, 4'b0001}) begin
         errors++; $display("FAIL lock_n1: ce/oce/app/rst/tick/busy %b required %b", {sce_m, oce_m, app_m, arst_m, tick_m, busy_m}, {1'b1, EXP_OCE, 4'b0001});
      end
      cyc();
      checks++;
      if ({sce_m, oce_m, app_m, arst_m, tick_m} !== 5'b00100) begin
         errors++; $display("FAIL lock_n2: %b required 00100", {sce_m, oce_m, app_m, arst_m, tick_m});
      end
      cyc();
      checks++;
      if ({sce_m, oce_m, app_m, arst_m, tick_m} !== 5'b00010) begin
         errors++; $display("FAIL lock_n3: %b required 00010", {sce_m, oce_m, app_m, arst_m, tick_m});
      end
      cyc();
      checks++;
      if ({sce_m, oce_m, app_m, arst_m, tick_m} !== 5'b00001) begin
         errors++; $display("FAIL lock_n4: %b required 00001", {sce_m, oce_m, app_m, arst_m, tick_m});
      end
      wait_tick_m(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lock_tick_wait: no tick within bound"); end
      pulse_done_m();        // edge M; now EVAL
      checks++;
      if (busy_m !== 1'b1 || lock_m !== 1'b0) begin
         errors++; $display("FAIL lock_eval: busy %b lock %b required 1/0", busy_m, lock_m);
      end
      cyc();                 // M+2, DONE
      checks++;
      if (lock_m !== 1'b1 || to_m !== 1'b0 || iter_m !== 8'd1 || busy_m !== 1'b1) begin
         errors++; $display("FAIL lock_done: lock %b to %b iter %0d busy %b required 1/0/1/1", lock_m, to_m, iter_m, busy_m);
      end
      checks++;
      if (scale_m !== 17'h04000 || sce_m !== 1'b0) begin
         errors++; $display("FAIL lock_scale: scale %h ce %b required 04000/0", scale_m, sce_m);
      end
      cyc();                 // M+3
      checks++;
      if (busy_m !== 1'b0 || lock_m !== 1'b1) begin
         errors++; $display("FAIL lock_idle: busy %b lock %b required 0/1", busy_m, lock_m);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      logic [16:0] exp_scale;
      logic [16:0] stp;
      sq_m = 24'h800000; gt = 21'd0; lt = 21'd0;
      exp_scale = 17'd16384;
      start_m = 1'b1;
      cyc();
      start_m = 1'b0;
      for (int i = 0; i < 32; i++) begin
         wait_tick_m(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL timeout_tick_wait: iteration %0d no tick", i);
            break;
         end
         checks++;
         if (scale_m !== exp_scale || iter_m !== i[7:0]) begin
            errors++; $display("FAIL timeout_iter%0d: scale %0d iter %0d required %0d/%0d", i, scale_m, iter_m, exp_scale, i);
         end
         pulse_done_m();
         if (i < 31) begin
            stp = exp_scale >> 4;
            if (stp == 17'd0) stp = 17'd1;
            exp_scale = (exp_scale > stp) ? exp_scale - stp : 17'd1;
         end
      end
      cyc();                 // DONE
      checks++;
      if (to_m !== 1'b1 || lock_m !== 1'b0 || iter_m !== 8'd32) begin
         errors++; $display("FAIL timeout_done: to %b lock %b iter %0d required 1/0/32", to_m, lock_m, iter_m);
      end
      checks++;
      if (scale_m !== exp_scale) begin
         errors++; $display("FAIL timeout_scale: scale %0d required %0d", scale_m, exp_scale);
      end
      cyc();
      checks++;
      if (busy_m !== 1'b0) begin
         errors++; $display("FAIL timeout_idle: busy %b required 0", busy_m);
      end
   endtask

`ifdef AGC_SERVO_OFFSET_EN
   task automatic test_offset();
      bit ok;
      logic [7:0] exp_off;
      sq_m = 24'h200000; gt = 21'd5000; lt = 21'd0;
      exp_off = 8'h00;
      start_m = 1'b1;
      cyc();
      start_m = 1'b0;
      for (int i = 0; i < 32; i++) begin
         wait_tick_m(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL offset_tick_wait: iteration %0d no tick", i);
            break;
         end
         checks++;
         if (off_m !== exp_off) begin
            errors++; $display("FAIL offset_iter%0d: offset %h required %h", i, off_m, exp_off);
         end
         pulse_done_m();
         if (i < 31 && exp_off != 8'h80) exp_off = exp_off - 8'd1;
      end
      cyc();
      checks++;
      if (to_m !== 1'b1 || lock_m !== 1'b0 || off_m !== exp_off) begin
         errors++; $display("FAIL offset_done: to %b lock %b off %h required 1/0/%h", to_m, lock_m, off_m, exp_off);
      end
      cyc();
   endtask
`else
   task automatic test_offset();
      bit ok;
      sq_m = 24'h200000; gt = 21'd5000; lt = 21'd0;
      start_m = 1'b1;
      cyc();
      start_m = 1'b0;
      checks++;
      if (sce_m !== 1'b1 || oce_m !== 1'b0) begin
         errors++; $display("FAIL offset_ce: ce %b oce %b required 1/0", sce_m, oce_m);
      end
      wait_tick_m(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL offset_tick_wait: no tick"); end
      pulse_done_m();
      cyc();
      checks++;
      if (lock_m !== 1'b1 || iter_m !== 8'd1 || off_m !== 8'h00) begin
         errors++; $display("FAIL offset_disabled: lock %b iter %0d off %h required 1/1/00", lock_m, iter_m, off_m);
      end
      cyc();
   endtask
`endif

   task automatic test_abort();
      bit ok;
      sq_m = 24'h200000; gt = 21'd0; lt = 21'd0;
      start_m = 1'b1;
      cyc();
      start_m = 1'b0;
      wait_tick_m(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL abort_tick_wait: no tick"); end
      cyc();                 // WAIT
      abort_m = 1'b1;
      cyc();
      abort_m = 1'b0;
      checks++;
      if (busy_m !== 1'b0 || lock_m !== 1'b0 || to_m !== 1'b0 || scale_m !== 17'h04000) begin
         errors++; $display("FAIL abort_state: busy %b lock %b to %b scale %h required 0/0/0/04000", busy_m, lock_m, to_m, scale_m);
      end
      done_m = 1'b1;         // stray done in IDLE
      cyc();
      done_m = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if ({tick_m, arst_m, sce_m, oce_m, app_m, busy_m, lock_m} !== 7'b0) begin
            errors++; $display("FAIL abort_stray_done: pulses/busy/lock %b required 0", {tick_m, arst_m, sce_m, oce_m, app_m, busy_m, lock_m});
         end
      end
      start_m = 1'b1; abort_m = 1'b1;
      cyc();
      start_m = 1'b0; abort_m = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({tick_m, arst_m, sce_m, oce_m, app_m, busy_m} !== 6'b0) begin
            errors++; $display("FAIL abort_beats_start: pulses/busy %b required 0", {tick_m, arst_m, sce_m, oce_m, app_m, busy_m});
         end
         cyc();
      end
   endtask

   task automatic test_rst_midrun();
      start_m = 1'b1;
      cyc();
      start_m = 1'b0;
      cyc();                 // APPLY cycle
      checks++;
      if (app_m !== 1'b1) begin
         errors++; $display("FAIL rst_pre_apply: apply %b required 1", app_m);
      end
      rst = 1'b1;
      cyc();
      checks++;
      if ({tick_m, arst_m, sce_m, oce_m, app_m, busy_m} !== 6'b0 || scale_m !== 17'h04000) begin
         errors++; $display("FAIL rst_midrun: pulses/busy %b scale %h required 0/04000", {tick_m, arst_m, sce_m, oce_m, app_m, busy_m}, scale_m);
      end
      rst = 1'b0;
      cyc();
      cyc();
      checks++;
      if ({tick_m, arst_m, busy_m} !== 3'b0) begin
         errors++; $display("FAIL rst_after: tick/rst/busy %b required 000", {tick_m, arst_m, busy_m});
      end
   endtask

   task automatic test_scale_edges();
      bit ok;
      start_e = 1'b1;
      cyc();
      start_e = 1'b0;
      for (int it = 0; it < 2; it++) begin
         wait_tick_e(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL edge_tick_wait: iteration %0d no tick", it);
            break;
         end
         cyc();
         done_e = 1'b1;
         cyc();              // edge M
         done_e = 1'b0;
         cyc();              // M+2: LOAD with new scale
         checks++;
         if (scale_lo !== 17'd1 || sce_lo !== 1'b1) begin
            errors++; $display("FAIL edge_floor%0d: scale %h ce %b required 00001/1", it, scale_lo, sce_lo);
         end
         checks++;
         if (scale_hi !== 17'h1FFFF || sce_hi !== 1'b1) begin
            errors++; $display("FAIL edge_sat%0d: scale %h ce %b required 1ffff/1", it, scale_hi, sce_hi);
         end
      end
      abort_e = 1'b1;
      cyc();
      abort_e = 1'b0;
      checks++;
      if (busy_lo !== 1'b0 || busy_hi !== 1'b0) begin
         errors++; $display("FAIL edge_abort: busy lo %b hi %b required 0/0", busy_lo, busy_hi);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_timeout();
      test_offset();
      test_abort();
      test_rst_midrun();
      test_scale_edges();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_agc_servo
`default_nettype wire
